barrido_display_multiplexado: RTL
=================================

Name: barrido_display_multiplexado

Overview:
- Parametrised scanner for an N-digit, common-anode, multiplexed 7-segment display.
- Runs the refresh prescaler and digit position counter internally, decodes per-digit hex nibbles, and drives active-low anodes, segments and decimal point.
- Adds double-buffered display data, per-digit blanking, PWM brightness and anti-ghosting guard time.
- Sits between game/score logic and the board display pins.

Parameters:
- NUM_DIGITOS, 4: number of digits/anodes, 2..8.
- DIV_REFRESCO, 50000: clock cycles each digit slot lasts, ≥ 2^ANCHO_BRILLO, ≥ GUARDA+1.
- ANCHO_BRILLO, 3: width of brightness input.
- GUARDA, 2: cycles at slot start with all anodes off (anti-ghosting).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- datos  in  4*NUM_DIGITOS  hex nibble per digit; digit i = datos[4i+3:4i].
- puntos  in  NUM_DIGITOS  decimal point per digit, 1 = lit.
- habilitar  in  NUM_DIGITOS  per-digit enable, 0 = digit blanked.
- brillo  in  ANCHO_BRILLO  brightness level, 0 = dark, max = full.
- actualizar  in  1  strobe: capture datos/puntos/habilitar into shadow.
- anodo  out  NUM_DIGITOS  active-low anode selects, at most one low.
- segmentos  out  7  active-low segments {g,f,e,d,c,b,a}.
- punto  out  1  active-low decimal point.
- posicion  out  clog2(NUM_DIGITOS)  digit currently scanned.
- fin_barrido  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: all state updates only on the rising clk edge and reset is sampled there.
- Reset values:
  - anodo all 1, segmentos 7'h7F, punto 1.
  - posicion 0, fin_barrido 0, prescaler cuenta 0.
  - Shadow and active registers 0; pendiente 0.
- Prescaler: cuenta counts 0..DIV_REFRESCO-1.
- At cuenta = DIV_REFRESCO-1:
  - cuenta returns to 0 and posicion increments.
  - At posicion = NUM_DIGITOS-1, posicion wraps to 0 and fin_barrido pulses for that one cycle.
- Double buffer:
  - actualizar=1 loads the shadow registers from datos/puntos/habilitar and sets pendiente.
  - On a wrap cycle with pendiente=1, active registers take the shadow content held before that edge, and pendiente clears.
  - actualizar coincident with a wrap: the new capture goes to shadow, pendiente stays 1, and the transfer happens at the next wrap.
  - The displayed frame never mixes old and new data.
- Brightness window:
  - ventana = ((brillo+1)*DIV_REFRESCO) >> ANCHO_BRILLO, computed at full width with no overflow.
  - Anode of posicion is driven low when GUARDA ≤ cuenta < ventana and habilitar_act[posicion]=1; otherwise all anodes are 1.
  - If ventana ≤ GUARDA the digit stays dark.
- Segments:
  - Active-low hex decode of the active nibble at posicion.
  - Values: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
  - Blanked digit or anode-off cycle: segmentos=7'h7F, punto=1.
  - Otherwise punto = ~puntos_act[posicion].
- Latency: anodo/segmentos/punto are registered, so they lag cuenta/posicion by exactly 1 cycle. The last slot cycle's output reflects the old posicion.
- brillo is sampled every cycle; a change mid-slot takes effect on the next cycle.
- Reset mid-scan returns all outputs to reset values on the next edge; the active data is lost.

Test Plan (NUM_DIGITOS=4, DIV_REFRESCO=16, ANCHO_BRILLO=3, GUARDA=2):
- Reset held 3 cycles, then released with brillo=7 -> anodo=1111 and segmentos=7F during reset. posicion steps 0,1,2,3,0 every 16 cycles. fin_barrido is high 1 cycle every 64.
- datos=16'hF810, habilitar=1111, actualizar pulse, brillo=7 -> after the next wrap: digit0 1000000/anodo 1110, digit1 1111001/1101, digit2 0000000/1011, digit3 0001110/0111. Each digit is lit 14 cycles per slot (cuenta 2..15).
- brillo=3 -> anode low 6 cycles per slot. brillo=0 -> ventana=2, so all anodes stay 1111 permanently.
- habilitar=1011, puntos=0100 -> slot 2 anodo stays 1111 with segmentos 7F. Slot 0 has punto=1; a lit punto=0 appears only on a digit whose puntos bit is 1 and that is enabled.
- actualizar with new datos mid-frame (posicion=1) -> displayed digits 1..3 keep old values until fin_barrido, then all switch together. actualizar on the wrap cycle -> change appears one frame later.
- reset asserted at posicion=2, cuenta=9 -> next cycle anodo=1111 and posicion=0. After release, digits are blank-decoded as 0 until the next actualizar+wrap.

Source files
------------

// File: rtl/barrido_display_multiplexado_if.sv
// Signal bundle between the score/game logic and the multiplexed display scanner.
// The master drives digit data and controls; the slave drives the display pins.
interface barrido_display_multiplexado_if #(
    parameter int NUM_DIGITOS  = 4,
    parameter int ANCHO_BRILLO = 3
);
    localparam int ANCHO_POS = $clog2(NUM_DIGITOS);

    logic [4*NUM_DIGITOS-1:0] datos;
    logic [NUM_DIGITOS-1:0]   puntos;
    logic [NUM_DIGITOS-1:0]   habilitar;
    logic [ANCHO_BRILLO-1:0]  brillo;
    logic                     actualizar;
    logic [NUM_DIGITOS-1:0]   anodo;
    logic [6:0]               segmentos;
    logic                     punto;
    logic [ANCHO_POS-1:0]     posicion;
    logic                     fin_barrido;

    modport master (
        output datos, puntos, habilitar, brillo, actualizar,
        input  anodo, segmentos, punto, posicion, fin_barrido
    );

    modport slave (
        input  datos, puntos, habilitar, brillo, actualizar,
        output anodo, segmentos, punto, posicion, fin_barrido
    );
endinterface

// File: rtl/barrido_display_multiplexado.sv
// Common-anode multiplexed 7-segment scanner with double-buffered frame data,
// per-digit blanking, PWM brightness window and anti-ghosting guard time.
module barrido_display_multiplexado #(
    parameter int NUM_DIGITOS  = 4,
    parameter int DIV_REFRESCO = 50000,
    parameter int ANCHO_BRILLO = 3,
    parameter int GUARDA       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    barrido_display_multiplexado_if.slave bus
);
    localparam int ANCHO_POS = $clog2(NUM_DIGITOS);
    localparam int ANCHO_CTA = $clog2(DIV_REFRESCO);
    localparam int ANCHO_VEN = ANCHO_BRILLO + 1 + $clog2(DIV_REFRESCO + 1);

    logic [ANCHO_CTA-1:0]     r_cuenta;
    logic [ANCHO_POS-1:0]     r_posicion;
    logic [4*NUM_DIGITOS-1:0] r_datos_sh, r_datos_act;
    logic [NUM_DIGITOS-1:0]   r_puntos_sh, r_puntos_act;
    logic [NUM_DIGITOS-1:0]   r_hab_sh, r_hab_act;
    logic                     r_pendiente;
    logic [NUM_DIGITOS-1:0]   r_anodo_p1;
    logic [6:0]               r_seg_p1;
    logic                     r_punto_p1;

    logic                     w_fin_slot;
    logic                     w_wrap;
    logic                     w_encendido;
    logic [ANCHO_VEN-1:0]     w_ventana;
    logic [ANCHO_VEN-1:0]     w_cuenta_ext;
    logic [3:0]               w_nibble;

    function automatic logic [6:0] hex_a_7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_fin_slot = (r_cuenta == ANCHO_CTA'(DIV_REFRESCO - 1));
    assign w_wrap     = w_fin_slot && (r_posicion == ANCHO_POS'(NUM_DIGITOS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cuenta   <= '0;
            r_posicion <= '0;
        end else if (w_fin_slot) begin
            r_cuenta   <= '0;
            r_posicion <= w_wrap ? '0 : r_posicion + ANCHO_POS'(1);
        end else begin
            r_cuenta   <= r_cuenta + ANCHO_CTA'(1);
        end
    end

    // Active copy only changes on a frame wrap, so one frame never mixes two captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_datos_sh   <= '0;
            r_puntos_sh  <= '0;
            r_hab_sh     <= '0;
            r_datos_act  <= '0;
            r_puntos_act <= '0;
            r_hab_act    <= '0;
            r_pendiente  <= 1'b0;
        end else begin
            if (bus.actualizar) begin
                r_datos_sh  <= bus.datos;
                r_puntos_sh <= bus.puntos;
                r_hab_sh    <= bus.habilitar;
            end
            if (w_wrap && r_pendiente) begin
                r_datos_act  <= r_datos_sh;
                r_puntos_act <= r_puntos_sh;
                r_hab_act    <= r_hab_sh;
            end
            if (bus.actualizar)
                r_pendiente <= 1'b1;
            else if (w_wrap)
                r_pendiente <= 1'b0;
        end
    end

    assign w_ventana    = ((ANCHO_VEN'(bus.brillo) + ANCHO_VEN'(1)) * ANCHO_VEN'(DIV_REFRESCO))
                          >> ANCHO_BRILLO;
    assign w_cuenta_ext = ANCHO_VEN'(r_cuenta);
    assign w_encendido  = (w_cuenta_ext >= ANCHO_VEN'(GUARDA)) && (w_cuenta_ext < w_ventana)
                          && r_hab_act[r_posicion];

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (r_posicion == ANCHO_POS'(i))
                w_nibble = r_datos_act[4*i +: 4];
        end
    end

    // Output stage p1: pins lag the scan counters by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anodo_p1 <= '1;
            r_seg_p1   <= 7'h7F;
            r_punto_p1 <= 1'b1;
        end else if (w_encendido) begin
            r_anodo_p1 <= ~(NUM_DIGITOS'(1) << r_posicion);
            r_seg_p1   <= hex_a_7seg(w_nibble);
            r_punto_p1 <= ~r_puntos_act[r_posicion];
        end else begin
            r_anodo_p1 <= '1;
            r_seg_p1   <= 7'h7F;
            r_punto_p1 <= 1'b1;
        end
    end

    assign bus.anodo       = r_anodo_p1;
    assign bus.segmentos   = r_seg_p1;
    assign bus.punto       = r_punto_p1;
    assign bus.posicion    = r_posicion;
    assign bus.fin_barrido = w_wrap;
endmodule
